store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write buffer between the core's data port (MemWrite/DataAdr/WriteData/ReadData) and a slow
//  word-wide data memory using a req/ack handshake. Stores retire to the core in one cycle and drain
//  in FIFO order; loads forward from buffered stores or go to memory. Stall freezes the core (PC, regs).
// PARAMETERS
//  DEPTH  4  number of buffered stores; power of two, >= 2
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-high
//  MemWrite   in   1   core store request (already condition-qualified)
//  MemRead    in   1   core load request (LDR, condition-qualified)
//  DataAdr    in   32  core byte address; word-aligned, compare on [31:2]
//  WriteData  in   32  core store data
//  ReadData   out  32  load data to core
//  Stall      out  1   core must hold current instruction this cycle
//  sb_empty   out  1   buffer holds no stores and no drain outstanding
//  mem_req    out  1   memory request valid
//  mem_we     out  1   1 = write, 0 = read; valid while mem_req
//  mem_addr   out  32  memory word address (byte address, [1:0]=0)
//  mem_wdata  out  32  memory write data
//  mem_ack    in   1   one-cycle pulse: request complete; mem_rdata valid same cycle for reads
//  mem_rdata  in   32  memory read data
// BEHAVIOUR
//  Reset: FIFO emptied (rd/wr ptr=0, count=0), state IDLE; mem_req=0, mem_we=0, mem_addr=0,
//   mem_wdata=0, Stall=0, ReadData=0, sb_empty=1. Reset mid-transaction abandons it; acks in IDLE ignored.
//  FIFO: entries {addr[31:2], data}; ptrs wrap mod DEPTH; count 0..DEPTH.
//  Store: MemWrite & count<DEPTH -> enqueue at clock edge, Stall=0. MemWrite & count==DEPTH -> Stall=1,
//   no enqueue (even if a drain ack arrives that cycle; accepted next cycle).
//  Load hit: MemRead & addr matches any entry -> ReadData = data of YOUNGEST matching entry, combinational,
//   Stall=0, no memory access. The entry being drained (head) counts as buffered until its ack.
//  Load miss: Stall=1 until load completes; on ack cycle ReadData=mem_rdata, Stall=0, core proceeds.
//  MemRead & MemWrite both high: not legal from the core; treat as store.
//  Neither: ReadData holds last value; Stall=0.
//  FSM (registered outputs mem_req/mem_we/mem_addr/mem_wdata):
//   IDLE : load miss pending -> LOAD (issue read next cycle); else count>0 -> DRAIN (issue head); else IDLE.
//   DRAIN: mem_req=1, mem_we=1, head addr/data held stable; on mem_ack dequeue head,
//          mem_req=0 for one cycle, -> IDLE. A load miss arriving here waits (Stall=1) for the ack.
//   LOAD : mem_req=1, mem_we=0, mem_addr=DataAdr held; on mem_ack -> IDLE, mem_req=0.
//  Priority in IDLE: load miss beats drain (no hazard: a miss has no conflicting buffered store).
//  mem_req deasserts for >=1 cycle between transactions; fields never change while mem_req=1.
//  Simultaneous enqueue and drain-ack: count unchanged, both ptrs advance.
//  Latency: store 1 cycle to core; load miss = 2 + memory latency cycles min (IDLE->LOAD->ack).
//  sb_empty = (count==0) & state!=DRAIN.
// TESTING
//  1 STR 0x64<-7 with mem_ack 3 cycles after req -> Stall=0 on store; mem_req/we=1 addr 0x64 data 7
//    held until ack; sb_empty=1 cycle after ack.
//  2 Five back-to-back STRs (DEPTH=4), ack withheld -> stores 1-4 accepted, 5th Stall=1 until first ack,
//    then accepted; memory sees writes in issue order.
//  3 STR 0x80<-5, STR 0x80<-9, LDR 0x80 before drain -> ReadData=9, Stall=0, no read on mem port.
//  4 LDR 0x40 (miss) while DRAIN outstanding -> Stall=1 through drain ack, read issued next
//    IDLE->LOAD, mem_rdata=0xDEADBEEF on ack -> ReadData=0xDEADBEEF, Stall=0.
//  5 Store enqueue in same cycle as drain ack with count=2 -> count stays 2, ptrs wrap correctly over
//    3*DEPTH stores.
//  6 reset asserted during LOAD with mem_req=1 -> next cycle mem_req=0, Stall=0, sb_empty=1;
//    late ack ignored.

Source files
------------

// File: rtl/store_buffer_if.sv
// ============================================================================
// Module   : store_buffer_if
// Purpose  : Core data-port and memory req/ack signals of the store buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface store_buffer_if;
    // Core side
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        sb_empty;
    // Memory side
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // Environment: the core plus the data memory
    modport master (
        output MemWrite, MemRead, DataAdr, WriteData, mem_ack, mem_rdata,
        input  ReadData, Stall, sb_empty, mem_req, mem_we, mem_addr, mem_wdata
    );

    // The store buffer itself
    modport slave (
        input  MemWrite, MemRead, DataAdr, WriteData, mem_ack, mem_rdata,
        output ReadData, Stall, sb_empty, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module   : store_buffer
// Purpose  : Posted-write FIFO with load forwarding between core and slow memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module store_buffer #(
    parameter int DEPTH = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    store_buffer_if.slave  sb
);

    localparam int c_PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [29:0]         r_fifo_addr [DEPTH];
    logic [31:0]         r_fifo_data [DEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W:0]    r_count;
    logic [31:0]         r_last_rdata;

    logic                r_mem_req;
    logic                r_mem_we;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                w_mem_req_nxt;
    logic                w_mem_we_nxt;
    logic [31:0]         w_mem_addr_nxt;
    logic [31:0]         w_mem_wdata_nxt;

    logic                w_is_store;
    logic                w_is_load;
    logic                w_full;
    logic                w_enq;
    logic                w_deq;
    logic                w_hit;
    logic [31:0]         w_hit_data;
    logic [c_PTR_W-1:0]  w_scan_idx;
    logic                w_load_miss;
    logic                w_load_done;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_unused = ^sb.DataAdr[1:0];

    // A simultaneous load and store from the core is treated as a store.
    assign w_is_store  = sb.MemWrite;
    assign w_is_load   = sb.MemRead & ~sb.MemWrite;
    assign w_full      = (r_count == (c_PTR_W+1)'(DEPTH));
    assign w_enq       = w_is_store & ~w_full;
    assign w_deq       = (r_state == S_DRAIN) & sb.mem_ack;
    assign w_load_miss = w_is_load & ~w_hit;
    assign w_load_done = w_load_miss & (r_state == S_LOAD) & sb.mem_ack;

    // Scan oldest to youngest so the last match wins; the head stays visible
    // while it is being drained, until its ack retires it.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        w_scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_scan_idx = r_rd_ptr + c_PTR_W'(i);
            if (((c_PTR_W+1)'(i) < r_count) &&
                (r_fifo_addr[w_scan_idx] == sb.DataAdr[31:2])) begin
                w_hit      = 1'b1;
                w_hit_data = r_fifo_data[w_scan_idx];
            end
        end
    end

    always_comb begin
        w_rdata = r_last_rdata;
        if (w_is_load && w_hit) begin
            w_rdata = w_hit_data;
        end else if (w_load_done) begin
            w_rdata = sb.mem_rdata;
        end
    end

    assign sb.ReadData  = w_rdata;
    assign sb.Stall     = (w_is_store & w_full) | (w_load_miss & ~w_load_done);
    assign sb.sb_empty  = (r_count == '0) & (r_state != S_DRAIN);
    assign sb.mem_req   = r_mem_req;
    assign sb.mem_we    = r_mem_we;
    assign sb.mem_addr  = r_mem_addr;
    assign sb.mem_wdata = r_mem_wdata;

    // Next-state and next memory-port fields; fields only change when a new
    // request is launched from IDLE, so they are stable while mem_req is high.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_load_miss) begin
                    w_state_nxt    = S_LOAD;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = {sb.DataAdr[31:2], 2'b00};
                end else if (r_count != '0) begin
                    w_state_nxt     = S_DRAIN;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = {r_fifo_addr[r_rd_ptr], 2'b00};
                    w_mem_wdata_nxt = r_fifo_data[r_rd_ptr];
                end
            end
            S_DRAIN, S_LOAD: begin
                if (sb.mem_ack) begin
                    w_state_nxt   = S_IDLE;
                    w_mem_req_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_last_rdata <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{c_PTR_W{1'b0}}, w_enq} - {{c_PTR_W{1'b0}}, w_deq};
            if (w_is_load && (w_hit || w_load_done)) begin
                r_last_rdata <= w_rdata;
            end
        end
    end

    // Entry storage needs no reset: only slots below the count are ever read.
    always_ff @(posedge clk) begin
        if (w_enq && !reset) begin
            r_fifo_addr[r_wr_ptr] <= sb.DataAdr[31:2];
            r_fifo_data[r_wr_ptr] <= sb.WriteData;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : Scenario bench for store_buffer with a req/ack memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_store_buffer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_buffer_if sb();

    store_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb.slave)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q [$];
    logic [63:0] obs_q [$];
    int          chk_idx = 0;

    // Memory model controls (written by the main sequence only)
    bit          auto_ack = 1'b0;
    int          ack_lat  = 1;
    int          ack_req_cnt = 0;
    logic [31:0] rd_value = '0;
    // Memory model observations (written by the model only)
    int          ack_done_cnt;
    int          n_reads;
    int          stab_viol;

    initial begin
        int          wait_cnt;
        bit          in_req;
        logic [64:0] held;
        wait_cnt     = 0;
        in_req       = 1'b0;
        held         = '0;
        ack_done_cnt = 0;
        n_reads      = 0;
        stab_viol    = 0;
        sb.mem_ack   = 1'b0;
        sb.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            sb.mem_ack = 1'b0;
            if (reset) begin
                wait_cnt = 0;
                in_req   = 1'b0;
            end else if (sb.mem_req) begin
                if (!in_req) begin
                    in_req   = 1'b1;
                    held     = {sb.mem_we, sb.mem_addr, sb.mem_wdata};
                    wait_cnt = 0;
                end else if ({sb.mem_we, sb.mem_addr, sb.mem_wdata} !== held) begin
                    stab_viol++;
                end
                wait_cnt++;
                if ((auto_ack && wait_cnt >= ack_lat) || (ack_req_cnt != ack_done_cnt)) begin
                    if (ack_req_cnt != ack_done_cnt) ack_done_cnt++;
                    sb.mem_ack = 1'b1;
                    in_req     = 1'b0;
                    if (sb.mem_we) begin
                        obs_q.push_back({sb.mem_addr, sb.mem_wdata});
                    end else begin
                        n_reads++;
                        sb.mem_rdata = rd_value;
                    end
                end
            end else begin
                in_req = 1'b0;
                if (ack_req_cnt != ack_done_cnt) begin
                    ack_done_cnt++;
                    sb.mem_ack = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic core(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        sb.MemWrite  = w;
        sb.MemRead   = r;
        sb.DataAdr   = a;
        sb.WriteData = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        core(0, 0, 32'h0, 32'h0);
        tick();
        tick();
        smp();
        total++;
        if ({sb.mem_req, sb.mem_we, sb.Stall, sb.sb_empty} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_flags: got req/we/stall/empty=%b want 0001",
                     {sb.mem_req, sb.mem_we, sb.Stall, sb.sb_empty});
        end
        total++;
        if ({sb.mem_addr, sb.mem_wdata, sb.ReadData} !== 96'h0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want all 0",
                     sb.mem_addr, sb.mem_wdata, sb.ReadData);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_store();
        int n;
        auto_ack = 1'b1;
        ack_lat  = 3;
        tick();
        core(1, 0, 32'h64, 32'd7);
        exp_q.push_back({32'h64, 32'd7});
        smp();
        total++;
        if (sb.Stall !== 1'b0) begin
            bad++; $display("FAIL t1_store_stall: got %b want 0", sb.Stall);
        end
        tick();
        core(0, 0, 32'h0, 32'h0);
        smp();
        total++;
        if (sb.sb_empty !== 1'b0) begin
            bad++; $display("FAIL t1_not_empty: got %b want 0", sb.sb_empty);
        end
        tick();
        smp();
        total++;
        if ({sb.mem_req, sb.mem_we, sb.mem_addr, sb.mem_wdata} !== {1'b1, 1'b1, 32'h64, 32'd7}) begin
            bad++;
            $display("FAIL t1_drain_req: got req=%b we=%b addr=%h data=%h want 1 1 00000064 00000007",
                     sb.mem_req, sb.mem_we, sb.mem_addr, sb.mem_wdata);
        end
        n = 1;
        while (!sb.mem_ack && n < 50) begin
            smp();
            n++;
        end
        total++;
        if (!sb.mem_ack || n != 3) begin
            bad++; $display("FAIL t1_ack_cycle: got ack=%b at req cycle %0d want 1 at 3", sb.mem_ack, n);
        end
        tick();
        smp();
        total++;
        if ({sb.sb_empty, sb.mem_req} !== 2'b10) begin
            bad++; $display("FAIL t1_after_ack: got empty/req=%b want 10", {sb.sb_empty, sb.mem_req});
        end
        for (int k = chk_idx; k < obs_q.size(); k++) begin
            total++;
            if (k >= exp_q.size() || obs_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL t1_write_order: got %h at %0d want %h", obs_q[k], k,
                                (k < exp_q.size()) ? exp_q[k] : 64'h0);
            end
        end
        chk_idx  = obs_q.size();
        auto_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        auto_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            core(1, 0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            smp();
            total++;
            if (sb.Stall !== (i == 4)) begin
                bad++; $display("FAIL t2_stall_store%0d: got %b want %b", i, sb.Stall, (i == 4));
            end
            if (i < 4) exp_q.push_back({32'h100 + 32'(4 * i), 32'hA0 + 32'(i)});
        end
        repeat (2) begin
            tick();
            smp();
            total++;
            if (sb.Stall !== 1'b1) begin
                bad++; $display("FAIL t2_full_hold: got %b want 1", sb.Stall);
            end
        end
        tick();
        ack_req_cnt++;
        smp();
        total++;
        if ({sb.Stall, sb.mem_ack} !== 2'b11) begin
            bad++; $display("FAIL t2_ack_cycle: got stall/ack=%b want 11", {sb.Stall, sb.mem_ack});
        end
        tick();
        smp();
        total++;
        if (sb.Stall !== 1'b0) begin
            bad++; $display("FAIL t2_fifth_accept: got %b want 0", sb.Stall);
        end
        exp_q.push_back({32'h110, 32'hA4});
        tick();
        core(0, 0, 32'h0, 32'h0);
        auto_ack = 1'b1;
        ack_lat  = 1;
        n = 0;
        while (!sb.sb_empty && n < 100) begin
            smp();
            n++;
        end
        total++;
        if (sb.sb_empty !== 1'b1) begin
            bad++; $display("FAIL t2_drain_timeout: got empty=%b want 1", sb.sb_empty);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("FAIL t2_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = chk_idx; k < obs_q.size(); k++) begin
            total++;
            if (k >= exp_q.size() || obs_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL t2_write_order: got %h at %0d want %h", obs_q[k], k,
                                (k < exp_q.size()) ? exp_q[k] : 64'h0);
            end
        end
        chk_idx  = obs_q.size();
        auto_ack = 1'b0;
    endtask

    task automatic test_forward();
        int n;
        int reads0;
        reads0   = n_reads;
        auto_ack = 1'b0;
        tick(); core(1, 0, 32'h80, 32'd5);    exp_q.push_back({32'h80, 32'd5});
        tick(); core(1, 0, 32'h88, 32'h33);   exp_q.push_back({32'h88, 32'h33});
        tick(); core(1, 0, 32'h80, 32'd9);    exp_q.push_back({32'h80, 32'd9});
        tick();
        core(0, 1, 32'h80, 32'h0);
        smp();
        total++;
        if ({sb.ReadData, sb.Stall} !== {32'd9, 1'b0}) begin
            bad++; $display("FAIL t3_youngest: got rdata=%h stall=%b want 00000009 0", sb.ReadData, sb.Stall);
        end
        tick();
        core(0, 1, 32'h88, 32'h0);
        smp();
        total++;
        if ({sb.ReadData, sb.Stall} !== {32'h33, 1'b0}) begin
            bad++; $display("FAIL t3_older_hit: got rdata=%h stall=%b want 00000033 0", sb.ReadData, sb.Stall);
        end
        tick();
        core(1, 1, 32'h90, 32'h77);
        exp_q.push_back({32'h90, 32'h77});
        smp();
        total++;
        if ({sb.Stall, sb.mem_req, sb.mem_we} !== 3'b011) begin
            bad++; $display("FAIL t3_both_as_store: got stall/req/we=%b want 011", {sb.Stall, sb.mem_req, sb.mem_we});
        end
        tick();
        core(0, 0, 32'h0, 32'h0);
        smp();
        total++;
        if (sb.ReadData !== 32'h33) begin
            bad++; $display("FAIL t3_rdata_hold: got %h want 00000033", sb.ReadData);
        end
        auto_ack = 1'b1;
        ack_lat  = 2;
        n = 0;
        while (!sb.sb_empty && n < 100) begin
            smp();
            n++;
        end
        total++;
        if (sb.sb_empty !== 1'b1 || n_reads != reads0) begin
            bad++; $display("FAIL t3_no_mem_read: got empty=%b reads=%0d want 1 %0d", sb.sb_empty, n_reads, reads0);
        end
        for (int k = chk_idx; k < obs_q.size(); k++) begin
            total++;
            if (k >= exp_q.size() || obs_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL t3_write_order: got %h at %0d want %h", obs_q[k], k,
                                (k < exp_q.size()) ? exp_q[k] : 64'h0);
            end
        end
        chk_idx  = obs_q.size();
        auto_ack = 1'b0;
    endtask

    task automatic test_load_miss();
        int reads0;
        reads0   = n_reads;
        auto_ack = 1'b0;
        tick(); core(1, 0, 32'h20, 32'd1); exp_q.push_back({32'h20, 32'd1});
        tick(); core(0, 0, 32'h0, 32'h0);
        tick();
        core(0, 1, 32'h40, 32'h0);
        smp();
        total++;
        if ({sb.Stall, sb.mem_req, sb.mem_we} !== 3'b111) begin
            bad++; $display("FAIL t4_miss_in_drain: got stall/req/we=%b want 111", {sb.Stall, sb.mem_req, sb.mem_we});
        end
        tick();
        smp();
        tick();
        ack_req_cnt++;
        smp();
        total++;
        if ({sb.Stall, sb.mem_ack} !== 2'b11) begin
            bad++; $display("FAIL t4_stall_drain_ack: got stall/ack=%b want 11", {sb.Stall, sb.mem_ack});
        end
        tick();
        smp();
        total++;
        if ({sb.Stall, sb.mem_req} !== 2'b10) begin
            bad++; $display("FAIL t4_gap_cycle: got stall/req=%b want 10", {sb.Stall, sb.mem_req});
        end
        tick();
        smp();
        total++;
        if ({sb.Stall, sb.mem_req, sb.mem_we, sb.mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h40}) begin
            bad++; $display("FAIL t4_read_issue: got stall=%b req=%b we=%b addr=%h want 1 1 0 00000040",
                            sb.Stall, sb.mem_req, sb.mem_we, sb.mem_addr);
        end
        tick();
        rd_value = 32'hDEADBEEF;
        ack_req_cnt++;
        smp();
        total++;
        if ({sb.ReadData, sb.Stall} !== {32'hDEADBEEF, 1'b0}) begin
            bad++; $display("FAIL t4_load_data: got rdata=%h stall=%b want deadbeef 0", sb.ReadData, sb.Stall);
        end
        tick();
        core(0, 0, 32'h0, 32'h0);
        smp();
        total++;
        if ({sb.ReadData, sb.mem_req} !== {32'hDEADBEEF, 1'b0} || n_reads != reads0 + 1) begin
            bad++; $display("FAIL t4_after_load: got rdata=%h req=%b reads=%0d want deadbeef 0 %0d",
                            sb.ReadData, sb.mem_req, n_reads, reads0 + 1);
        end
        for (int k = chk_idx; k < obs_q.size(); k++) begin
            total++;
            if (k >= exp_q.size() || obs_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL t4_write_order: got %h at %0d want %h", obs_q[k], k,
                                (k < exp_q.size()) ? exp_q[k] : 64'h0);
            end
        end
        chk_idx = obs_q.size();
    endtask

    task automatic test_wrap();
        int n;
        auto_ack = 1'b0;
        tick(); core(1, 0, 32'h300, 32'h500); exp_q.push_back({32'h300, 32'h500});
        tick(); core(1, 0, 32'h304, 32'h501); exp_q.push_back({32'h304, 32'h501});
        for (int it = 0; it < 12; it++) begin
            tick();
            ack_req_cnt++;
            core(1, 0, 32'h310 + 32'(4 * it), 32'h600 + 32'(it));
            exp_q.push_back({32'h310 + 32'(4 * it), 32'h600 + 32'(it)});
            smp();
            total++;
            if ({sb.Stall, sb.mem_ack} !== 2'b01) begin
                bad++; $display("FAIL t5_enq_with_ack%0d: got stall/ack=%b want 01", it, {sb.Stall, sb.mem_ack});
            end
            tick();
            core(0, 0, 32'h0, 32'h0);
            smp();
            total++;
            if (dut.r_count !== 3'd2 || sb.sb_empty !== 1'b0) begin
                bad++; $display("FAIL t5_count%0d: got count=%0d empty=%b want 2 0", it, dut.r_count, sb.sb_empty);
            end
        end
        auto_ack = 1'b1;
        ack_lat  = 1;
        n = 0;
        while (!sb.sb_empty && n < 100) begin
            smp();
            n++;
        end
        total++;
        if (obs_q.size() != exp_q.size() || sb.sb_empty !== 1'b1) begin
            bad++; $display("FAIL t5_drained: got writes=%0d empty=%b want %0d 1", obs_q.size(), sb.sb_empty, exp_q.size());
        end
        for (int k = chk_idx; k < obs_q.size(); k++) begin
            total++;
            if (k >= exp_q.size() || obs_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL t5_write_order: got %h at %0d want %h", obs_q[k], k,
                                (k < exp_q.size()) ? exp_q[k] : 64'h0);
            end
        end
        chk_idx  = obs_q.size();
        auto_ack = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int reads0;
        reads0   = n_reads;
        auto_ack = 1'b0;
        tick();
        core(0, 1, 32'h200, 32'h0);
        smp();
        total++;
        if (sb.Stall !== 1'b1) begin
            bad++; $display("FAIL t6_miss_stall: got %b want 1", sb.Stall);
        end
        tick();
        smp();
        total++;
        if ({sb.mem_req, sb.mem_we, sb.mem_addr} !== {1'b1, 1'b0, 32'h200}) begin
            bad++; $display("FAIL t6_load_req: got req=%b we=%b addr=%h want 1 0 00000200",
                            sb.mem_req, sb.mem_we, sb.mem_addr);
        end
        tick();
        reset = 1'b1;
        core(0, 0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
        ack_req_cnt++;
        smp();
        total++;
        if ({sb.mem_req, sb.Stall, sb.sb_empty, sb.mem_ack} !== 4'b0011) begin
            bad++; $display("FAIL t6_after_reset: got req/stall/empty/ack=%b want 0011",
                            {sb.mem_req, sb.Stall, sb.sb_empty, sb.mem_ack});
        end
        tick();
        smp();
        total++;
        if ({sb.mem_req, sb.sb_empty, sb.ReadData} !== {1'b0, 1'b1, 32'h0} || n_reads != reads0) begin
            bad++; $display("FAIL t6_late_ack_ignored: got req=%b empty=%b rdata=%h reads=%0d want 0 1 0 %0d",
                            sb.mem_req, sb.sb_empty, sb.ReadData, n_reads, reads0);
        end
    endtask

    initial begin
        reset = 1'b1;
        core(0, 0, 32'h0, 32'h0);
        test_reset();
        test_single_store();
        test_back_to_back();
        test_forward();
        test_load_miss();
        test_wrap();
        test_reset_mid_load();
        total++;
        if (stab_viol != 0) begin
            bad++; $display("FAIL mem_fields_stable: got %0d changes while req high want 0", stab_viol);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
